// File: rtl/ps2_rx_frontend.sv
// PS/2 device-to-host receiver: synchroniser, glitch filter, frame FSM, FWFT byte FIFO, clock inhibit.
// Optional macro PS2_RX_TIMEOUT_EN aborts frames that stall for TimeoutCycles clk_i cycles.
module ps2_rx_frontend #(
    parameter int unsigned FifoDepth     = 8,
    parameter int unsigned FilterLen     = 4,
    parameter int unsigned TimeoutCycles = 50000
) (
    input  logic       clk_i,
    input  logic       rst_ni,
    input  logic       ps2_clk_i,
    input  logic       ps2_dat_i,
    output logic       ps2_clk_oe_o,
    output logic [7:0] data_o,
    output logic       valid_o,
    input  logic       ready_i,
    output logic       parity_err_o,
    output logic       frame_err_o,
    output logic       overflow_o
);
    localparam int unsigned    PtrW   = (FifoDepth > 1) ? $clog2(FifoDepth) : 1;
    localparam int unsigned    CntW   = PtrW + 1;
    localparam int unsigned    FltW   = (FilterLen > 1) ? $clog2(FilterLen) : 1;
    localparam logic [FltW-1:0] FltMax = FltW'(FilterLen - 1);
    localparam logic [CntW-1:0] Full   = CntW'(FifoDepth);

    if (FifoDepth < 2 || (FifoDepth & (FifoDepth - 1)) != 0 || FilterLen < 1 || TimeoutCycles < 1)
    begin : g_param_check
        $error("ps2_rx_frontend: illegal parameter value");
    end

    typedef enum logic [1:0] {StIdle, StData, StParity, StStop} state_e;

    // Index 0 carries the PS/2 clock, index 1 the PS/2 data.
    logic [1:0]           meta_q, sync_q, filt_q, filt_d;
    logic [1:0][FltW-1:0] fcnt_q, fcnt_d;
    logic                 prev_clk_q;
    logic                 strobe, bit_in, timeout;

    state_e               state_q, state_d;
    logic [2:0]           bitcnt_q, bitcnt_d;
    logic [7:0]           shift_q, shift_d;
    logic                 ok_q, ok_d;

    logic                 stop_hit, push, pop, full, wr_en;
    logic [PtrW-1:0]      wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [CntW-1:0]      count_q, count_d;
    logic [7:0]           mem_q [FifoDepth];
    logic                 oe_q, oe_d;
    logic                 parity_err_q, parity_err_d;
    logic                 frame_err_q, frame_err_d;
    logic                 overflow_q, overflow_d;

    always_comb begin
        filt_d = filt_q;
        fcnt_d = fcnt_q;
        for (int unsigned i = 0; i < 2; i++) begin
            if (sync_q[i] == filt_q[i]) begin
                fcnt_d[i] = '0;
            end else if (fcnt_q[i] == FltMax) begin
                filt_d[i] = sync_q[i];
                fcnt_d[i] = '0;
            end else begin
                fcnt_d[i] = fcnt_q[i] + 1'b1;
            end
        end
    end

    assign strobe = prev_clk_q & ~filt_q[0];
    assign bit_in = filt_q[1];

    always_comb begin
        state_d = state_q;
        if (timeout) begin
            state_d = StIdle;
        end else if (strobe) begin
            case (state_q)
                StIdle:   if (!bit_in) state_d = StData;
                StData:   if (bitcnt_q == 3'd7) state_d = StParity;
                StParity: state_d = StStop;
                default:  state_d = StIdle;
            endcase
        end
    end

    always_comb begin
        bitcnt_d = bitcnt_q;
        shift_d  = shift_q;
        ok_d     = ok_q;
        if (timeout) begin
            bitcnt_d = '0;
            shift_d  = '0;
        end else if (strobe) begin
            case (state_q)
                StIdle:   bitcnt_d = '0;
                StData: begin
                    shift_d  = {bit_in, shift_q[7:1]};
                    bitcnt_d = bitcnt_q + 1'b1;
                end
                StParity: ok_d = ^{shift_q, bit_in};
                default:  ;
            endcase
        end
    end

    always_comb begin
        stop_hit     = strobe && (state_q == StStop);
        push         = stop_hit && bit_in && ok_q;
        parity_err_d = stop_hit && bit_in && !ok_q;
        frame_err_d  = (stop_hit && !bit_in) || timeout;
    end

`ifdef PS2_RX_TIMEOUT_EN
    localparam int unsigned    ToW    = $clog2(TimeoutCycles + 1);
    localparam logic [ToW-1:0] ToLast = ToW'(TimeoutCycles - 1);
    logic [ToW-1:0] to_cnt_q, to_cnt_d;

    always_comb begin
        to_cnt_d = to_cnt_q + 1'b1;
        timeout  = 1'b0;
        if (strobe || state_q == StIdle) begin
            to_cnt_d = '0;
        end else if (to_cnt_q == ToLast) begin
            timeout  = 1'b1;
            to_cnt_d = '0;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) to_cnt_q <= '0;
        else         to_cnt_q <= to_cnt_d;
    end
`else
    assign timeout = 1'b0;
`endif

    // A push into a full FIFO still lands when the same cycle pops.
    always_comb begin
        valid_o    = (count_q != '0);
        pop        = valid_o && ready_i;
        full       = (count_q == Full);
        wr_en      = push && (!full || pop);
        overflow_d = push && full && !pop;
        wr_ptr_d   = wr_en ? wr_ptr_q + 1'b1 : wr_ptr_q;
        rd_ptr_d   = pop ? rd_ptr_q + 1'b1 : rd_ptr_q;
        case ({wr_en, pop})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
        oe_d = (count_d == Full);
    end

    always_ff @(posedge clk_i) begin
        if (wr_en) mem_q[wr_ptr_q] <= shift_q;
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            meta_q       <= '1;
            sync_q       <= '1;
            filt_q       <= '1;
            fcnt_q       <= '0;
            prev_clk_q   <= 1'b1;
            state_q      <= StIdle;
            bitcnt_q     <= '0;
            shift_q      <= '0;
            ok_q         <= 1'b0;
            wr_ptr_q     <= '0;
            rd_ptr_q     <= '0;
            count_q      <= '0;
            oe_q         <= 1'b0;
            parity_err_q <= 1'b0;
            frame_err_q  <= 1'b0;
            overflow_q   <= 1'b0;
        end else begin
            meta_q       <= {ps2_dat_i, ps2_clk_i};
            sync_q       <= meta_q;
            filt_q       <= filt_d;
            fcnt_q       <= fcnt_d;
            prev_clk_q   <= filt_q[0];
            state_q      <= state_d;
            bitcnt_q     <= bitcnt_d;
            shift_q      <= shift_d;
            ok_q         <= ok_d;
            wr_ptr_q     <= wr_ptr_d;
            rd_ptr_q     <= rd_ptr_d;
            count_q      <= count_d;
            oe_q         <= oe_d;
            parity_err_q <= parity_err_d;
            frame_err_q  <= frame_err_d;
            overflow_q   <= overflow_d;
        end
    end

    assign data_o       = valid_o ? mem_q[rd_ptr_q] : '0;
    assign ps2_clk_oe_o = oe_q;
    assign parity_err_o = parity_err_q;
    assign frame_err_o  = frame_err_q;
    assign overflow_o   = overflow_q;
endmodule

// File: tb/tb_ps2_rx_frontend.sv
// Directed bench for ps2_rx_frontend: frames, errors, FIFO full/inhibit, glitches, timeout, reset.
module tb_ps2_rx_frontend;
    logic       clk_i = 1'b0;
    logic       rst_ni = 1'b0;
    logic       ps2_clk_i = 1'b1;
    logic       ps2_dat_i = 1'b1;
    logic       ready_i = 1'b0;
    logic       ps2_clk_oe_o;
    logic [7:0] data_o;
    logic       valid_o;
    logic       parity_err_o;
    logic       frame_err_o;
    logic       overflow_o;

    always #5 clk_i = ~clk_i;

    ps2_rx_frontend #(
        .FifoDepth(8),
        .FilterLen(4),
        .TimeoutCycles(1000)
    ) dut (
        .clk_i(clk_i),
        .rst_ni(rst_ni),
        .ps2_clk_i(ps2_clk_i),
        .ps2_dat_i(ps2_dat_i),
        .ps2_clk_oe_o(ps2_clk_oe_o),
        .data_o(data_o),
        .valid_o(valid_o),
        .ready_i(ready_i),
        .parity_err_o(parity_err_o),
        .frame_err_o(frame_err_o),
        .overflow_o(overflow_o)
    );

    int n_pass = 0;
    int n_chk  = 0;
    int n_par  = 0;
    int n_frm  = 0;
    int n_ovf  = 0;
    int n_vld  = 0;
    int cyc    = 0;
    int last_fall = 0;
    logic [7:0] rxq [$];

    always @(posedge clk_i) cyc++;

    always @(negedge clk_i) begin
        if (parity_err_o) n_par++;
        if (frame_err_o)  n_frm++;
        if (overflow_o)   n_ovf++;
        if (valid_o)      n_vld++;
        if (valid_o && ready_i) rxq.push_back(data_o);
    end

    task automatic tick(input int n);
        repeat (n) @(posedge clk_i);
        #1;
    endtask

    task automatic send_bit(input logic b);
        ps2_dat_i = b;
        tick(10);
        ps2_clk_i = 1'b0;
        last_fall = cyc;
        tick(20);
        ps2_clk_i = 1'b1;
        tick(10);
    endtask

    // glitch_at: bit index preceded by a 2-cycle low clock glitch (-1 for none)
    task automatic send_frame(input logic [7:0] d, input logic pflip, input logic stop,
                              input int glitch_at, input int nbits);
        logic [10:0] bits;
        bits = {stop, ~(^d) ^ pflip, d, 1'b0};
        for (int i = 0; i < nbits; i++) begin
            if (i == glitch_at) begin
                ps2_clk_i = 1'b0;
                tick(2);
                ps2_clk_i = 1'b1;
                tick(10);
            end
            send_bit(bits[i]);
        end
    endtask

    task automatic test_reset;
        tick(3);
        n_chk++; if (valid_o !== 1'b0) $display("FAIL reset_valid: got %b expected 0", valid_o); else n_pass++;
        n_chk++; if (data_o !== 8'h00) $display("FAIL reset_data: got %h expected 00", data_o); else n_pass++;
        n_chk++; if (ps2_clk_oe_o !== 1'b0) $display("FAIL reset_oe: got %b expected 0", ps2_clk_oe_o); else n_pass++;
        n_chk++; if ({parity_err_o, frame_err_o, overflow_o} !== 3'b000)
            $display("FAIL reset_pulses: got %b expected 000", {parity_err_o, frame_err_o, overflow_o}); else n_pass++;
        rst_ni = 1'b1;
        tick(5);
        n_chk++; if (valid_o !== 1'b0) $display("FAIL post_reset_valid: got %b expected 0", valid_o); else n_pass++;
    endtask

    task automatic test_good_frame;
        int bp, bf, bv;
        bp = n_par; bf = n_frm; bv = n_vld;
        ready_i = 1'b1;
        rxq.delete();
        send_frame(8'h1C, 1'b0, 1'b1, -1, 11);
        tick(10);
        n_chk++; if (rxq.size() !== 1) $display("FAIL good_count: got %0d expected 1", rxq.size()); else n_pass++;
        n_chk++; if (rxq[0] !== 8'h1C) $display("FAIL good_data: got %h expected 1c", rxq[0]); else n_pass++;
        n_chk++; if (n_vld - bv !== 1) $display("FAIL good_valid_cycles: got %0d expected 1", n_vld - bv); else n_pass++;
        n_chk++; if ((n_par - bp) + (n_frm - bf) !== 0)
            $display("FAIL good_no_err: got %0d expected 0", (n_par - bp) + (n_frm - bf)); else n_pass++;
    endtask

    task automatic test_errors;
        int bp, bf, bv;
        bp = n_par; bf = n_frm; bv = n_vld;
        send_frame(8'h1C, 1'b1, 1'b1, -1, 11);
        tick(10);
        n_chk++; if (n_par - bp !== 1) $display("FAIL parity_pulse: got %0d expected 1", n_par - bp); else n_pass++;
        n_chk++; if (n_vld - bv !== 0) $display("FAIL parity_no_push: got %0d expected 0", n_vld - bv); else n_pass++;
        send_frame(8'hF0, 1'b0, 1'b0, -1, 11);
        tick(10);
        n_chk++; if (n_frm - bf !== 1) $display("FAIL frame_pulse: got %0d expected 1", n_frm - bf); else n_pass++;
        n_chk++; if (n_par - bp !== 1) $display("FAIL frame_not_parity: got %0d expected 1", n_par - bp); else n_pass++;
        n_chk++; if (n_vld - bv !== 0) $display("FAIL frame_no_push: got %0d expected 0", n_vld - bv); else n_pass++;
        // bad stop outranks bad parity
        bp = n_par; bf = n_frm;
        send_frame(8'h3C, 1'b1, 1'b0, -1, 11);
        tick(10);
        n_chk++; if ({n_frm - bf, n_par - bp} !== {32'd1, 32'd0})
            $display("FAIL frame_precedence: got frm=%0d par=%0d expected 1/0", n_frm - bf, n_par - bp); else n_pass++;
    endtask

    task automatic test_overflow;
        int bo;
        logic [7:0] exp;
        ready_i = 1'b0;
        rxq.delete();
        bo = n_ovf;
        for (int i = 1; i <= 7; i++) send_frame(8'(i), 1'b0, 1'b1, -1, 11);
        n_chk++; if (ps2_clk_oe_o !== 1'b0) $display("FAIL oe_at_7: got %b expected 0", ps2_clk_oe_o); else n_pass++;
        n_chk++; if (data_o !== 8'h01) $display("FAIL head_at_7: got %h expected 01", data_o); else n_pass++;
        send_frame(8'h08, 1'b0, 1'b1, -1, 11);
        n_chk++; if (ps2_clk_oe_o !== 1'b1) $display("FAIL oe_at_8: got %b expected 1", ps2_clk_oe_o); else n_pass++;
        send_frame(8'h09, 1'b0, 1'b1, -1, 11);
        n_chk++; if (n_ovf - bo !== 1) $display("FAIL overflow_pulse: got %0d expected 1", n_ovf - bo); else n_pass++;
        n_chk++; if (data_o !== 8'h01) $display("FAIL head_after_ovf: got %h expected 01", data_o); else n_pass++;
        ready_i = 1'b1;
        n_chk++; if (ps2_clk_oe_o !== 1'b1) $display("FAIL oe_pop_cycle: got %b expected 1", ps2_clk_oe_o); else n_pass++;
        tick(1);
        n_chk++; if (ps2_clk_oe_o !== 1'b0) $display("FAIL oe_after_pop: got %b expected 0", ps2_clk_oe_o); else n_pass++;
        tick(12);
        n_chk++; if (rxq.size() !== 8) $display("FAIL drain_count: got %0d expected 8", rxq.size()); else n_pass++;
        for (int i = 0; i < 8; i++) begin
            exp = 8'(i + 1);
            n_chk++; if (rxq[i] !== exp) $display("FAIL drain_%0d: got %h expected %h", i, rxq[i], exp); else n_pass++;
        end
        n_chk++; if (valid_o !== 1'b0) $display("FAIL drain_empty: got %b expected 0", valid_o); else n_pass++;
    endtask

    task automatic test_glitch;
        int bp, bf, bv;
        bp = n_par; bf = n_frm; bv = n_vld;
        ready_i = 1'b1;
        rxq.delete();
        ps2_clk_i = 1'b0;
        tick(2);
        ps2_clk_i = 1'b1;
        tick(20);
        n_chk++; if (n_vld - bv !== 0) $display("FAIL glitch_idle_valid: got %0d expected 0", n_vld - bv); else n_pass++;
        send_frame(8'h5A, 1'b0, 1'b1, 4, 11);
        tick(10);
        n_chk++; if (rxq.size() !== 1) $display("FAIL glitch_count: got %0d expected 1", rxq.size()); else n_pass++;
        n_chk++; if (rxq[0] !== 8'h5A) $display("FAIL glitch_data: got %h expected 5a", rxq[0]); else n_pass++;
        n_chk++; if ((n_par - bp) + (n_frm - bf) !== 0)
            $display("FAIL glitch_no_err: got %0d expected 0", (n_par - bp) + (n_frm - bf)); else n_pass++;
    endtask

    task automatic test_timeout;
        int bf, lat;
        bf = n_frm;
        ready_i = 1'b1;
        rxq.delete();
        send_frame(8'hAA, 1'b0, 1'b1, -1, 4);
        while (n_frm == bf && (cyc - last_fall) < 1300) tick(1);
        lat = cyc - last_fall;
`ifdef PS2_RX_TIMEOUT_EN
        n_chk++; if (n_frm - bf !== 1) $display("FAIL timeout_pulse: got %0d expected 1", n_frm - bf); else n_pass++;
        n_chk++; if (lat < 995 || lat > 1020)
            $display("FAIL timeout_latency: got %0d expected 995..1020", lat); else n_pass++;
        tick(10);
        send_frame(8'hAA, 1'b0, 1'b1, -1, 11);
        tick(10);
        n_chk++; if (rxq.size() !== 1) $display("FAIL after_timeout_count: got %0d expected 1", rxq.size()); else n_pass++;
        n_chk++; if (rxq[0] !== 8'hAA) $display("FAIL after_timeout_data: got %h expected aa", rxq[0]); else n_pass++;
        n_chk++; if (n_frm - bf !== 1) $display("FAIL after_timeout_err: got %0d expected 1", n_frm - bf); else n_pass++;
`else
        n_chk++; if (n_frm - bf !== 0) $display("FAIL no_timeout_pulse: got %0d expected 0 (waited %0d)", n_frm - bf, lat); else n_pass++;
        rst_ni = 1'b0;
        tick(3);
        rst_ni = 1'b1;
        tick(5);
`endif
    endtask

    task automatic test_reset_mid_frame;
        int bp, bf;
        ready_i = 1'b0;
        send_frame(8'h33, 1'b0, 1'b1, -1, 11);
        n_chk++; if (valid_o !== 1'b1) $display("FAIL prefill_valid: got %b expected 1", valid_o); else n_pass++;
        send_frame(8'h12, 1'b0, 1'b1, -1, 5);
        rst_ni = 1'b0;
        #1;
        n_chk++; if (valid_o !== 1'b0) $display("FAIL midreset_valid: got %b expected 0", valid_o); else n_pass++;
        n_chk++; if (data_o !== 8'h00) $display("FAIL midreset_data: got %h expected 00", data_o); else n_pass++;
        tick(3);
        rst_ni = 1'b1;
        tick(5);
        bp = n_par; bf = n_frm;
        ready_i = 1'b1;
        rxq.delete();
        send_frame(8'h12, 1'b0, 1'b1, -1, 11);
        tick(10);
        n_chk++; if (rxq.size() !== 1) $display("FAIL postreset_count: got %0d expected 1", rxq.size()); else n_pass++;
        n_chk++; if (rxq[0] !== 8'h12) $display("FAIL postreset_data: got %h expected 12", rxq[0]); else n_pass++;
        n_chk++; if ((n_par - bp) + (n_frm - bf) !== 0)
            $display("FAIL postreset_no_err: got %0d expected 0", (n_par - bp) + (n_frm - bf)); else n_pass++;
    endtask

    initial begin
        test_reset();
        test_good_frame();
        test_errors();
        test_overflow();
        test_glitch();
        test_timeout();
        test_reset_mid_frame();
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule

// File: doc/ps2_rx_frontend.md
Name: ps2_rx_frontend

Overview:
- Native PS/2 receive front end that replaces the vendor PS/2 IP on the keyboard/mouse path.
- Consumes the raw PS/2 clock and data pad inputs from the IOBUF outputs.
- Deserialises and checks 11-bit device-to-host frames, then buffers bytes in a small FIFO with a valid/ready output toward the TileLink register stage.
- Drives the PS/2 clock low (host inhibit) while its FIFO is full.

Parameters:
- FifoDepth, 8, number of buffered bytes; power of two, at least 2.
- FilterLen, 4, consecutive identical synchronised samples required before the filtered clock/data changes; at least 1.
- TimeoutCycles, 50000, idle clk_i cycles tolerated mid-frame; used only with PS2_RX_TIMEOUT_EN.

Ports:
- clk_i  input  1  system clock.
- rst_ni  input  1  asynchronous active-low reset.
- ps2_clk_i  input  1  raw PS/2 clock from the pad.
- ps2_dat_i  input  1  raw PS/2 data from the pad.
- ps2_clk_oe_o  output  1  1 = pull PS/2 clock low (inhibit); feeds IOBUF T/I logic.
- data_o  output  8  received byte at FIFO head.
- valid_o  output  1  FIFO not empty.
- ready_i  input  1  consumer accepts data_o this cycle.
- parity_err_o  output  1  one-cycle pulse, frame dropped for bad parity.
- frame_err_o  output  1  one-cycle pulse, frame dropped for bad stop bit or timeout.
- overflow_o  output  1  one-cycle pulse, good byte dropped because the FIFO was full.

Behaviour:
- Reset (async assert, sync deassert via rst_ni):
  - FSM in IDLE; FIFO empty; all outputs 0; data_o 0x00.
  - Synchroniser and filter state reset to 1 (idle-high bus).
- Input conditioning:
  - 2-FF synchroniser on each pad input.
  - Filter counter per signal: the filtered value updates only after FilterLen consecutive samples differ from it.
- Strobe: a one-cycle pulse on the filtered-clock 1->0 transition. Data is sampled from the filtered data on the strobe cycle.
- FSM, acting only on strobe cycles:
  - IDLE: data 0 -> DATA with bitcnt=0. Data 1 -> stay in IDLE (stray edge, no error).
  - DATA: shift right, new bit into bit 7 (LSB first). bitcnt increments; after the 8th bit -> PARITY.
  - PARITY: store ok = XOR(shift[7:0], bit) == 1 (odd parity). Go to STOP.
  - STOP:
    - bit 1 and ok -> push.
    - bit 1 and !ok -> parity_err_o pulse.
    - bit 0 -> frame_err_o pulse; takes precedence over a parity error.
    - Always return to IDLE.
- Error and overflow pulses assert on the cycle after the stop-bit strobe.
- FIFO:
  - First-word fall-through: data_o = head, valid_o = !empty.
  - Pop when valid_o && ready_i.
  - A pushed byte appears on data_o / valid_o the cycle after the stop-bit strobe if the FIFO was empty.
  - Simultaneous push and pop: both occur and the count is unchanged, including when full, so no overflow in that case.
  - Push while full without a pop: byte discarded, overflow_o pulses, FIFO contents unchanged.
  - Pointers wrap modulo FifoDepth. Count width is clog2(FifoDepth)+1.
- Inhibit: ps2_clk_oe_o is registered and equals full, so it asserts the cycle after the FIFO becomes full and deasserts the cycle after the first pop from full.
- Inhibit overlapping a frame in progress: the FSM is not reset; the device aborts by PS/2 protocol and retransmits. A later stray start is tolerated via the timeout when enabled.
- Reset mid-frame discards the partial frame; the next frame starts clean.

Optional Feature:
- Macro: PS2_RX_TIMEOUT_EN.
- Enabled:
  - A counter clears on every strobe and in IDLE, and increments every cycle while in DATA, PARITY or STOP.
  - When it reaches TimeoutCycles: frame_err_o pulses, FSM returns to IDLE, partial byte discarded, counter cleared.
- Disabled: no counter logic; a partial frame waits indefinitely for further edges.

Test Plan:
- Frame 0x1C: start 0; bits 0,0,1,1,1,0,0,0; parity 0; stop 1; ready_i=1 -> valid_o=1 with data_o=0x1C one cycle after the stop strobe, then popped; no error pulses.
- Same frame with parity 1 -> parity_err_o pulses once; valid_o stays 0. Frame 0xF0 with stop 0 -> frame_err_o pulses once; no push.
- ready_i=0, FifoDepth=8, send bytes 0x01..0x09:
  - After the 8th byte -> ps2_clk_oe_o=1.
  - 9th byte -> overflow_o pulses once.
  - Then raise ready_i -> 0x01..0x08 drain in order; ps2_clk_oe_o drops the cycle after the first pop.
- Glitches with FilterLen=4: 2-cycle low pulses on ps2_clk_i in IDLE and mid-frame -> no strobe, no state change; the following valid frame 0x5A is received intact.
- PS2_RX_TIMEOUT_EN, TimeoutCycles=1000: start plus 3 data bits, then silence -> frame_err_o pulses 1000 cycles after the last edge; the next frame 0xAA is received correctly. Without the macro -> no pulse.
- Assert rst_ni after 5 bits of a frame -> outputs 0 and FIFO empty. After release, full frame 0x12 -> data_o=0x12 with no errors.
